// File: rtl/win_detector.sv
// Goal-tile win detector: registers goal overlap, requires a dwell of frame ticks,
// then requests a level change and retries until it is acknowledged.
module win_detector #(
  parameter int unsigned DWELL_FRAMES   = 4,
  parameter int unsigned LOCKOUT_FRAMES = 8,
  parameter int unsigned ACK_TIMEOUT    = 4
) (
  input  logic        sim_clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic [31:0] playerState,
  input  logic [2:0]  level_num,
  input  logic        nextLevel,
  output logic        playerWin,
  output logic        in_goal,
  output logic [7:0]  win_count,
  output logic        busy
);

  typedef enum logic [2:0] {ARMED, DWELL, WIN, WAIT_ACK, LOCKOUT} state_e;

  localparam int DCW = (DWELL_FRAMES   < 1) ? 1 : $clog2(DWELL_FRAMES + 1);
  localparam int LCW = (LOCKOUT_FRAMES < 1) ? 1 : $clog2(LOCKOUT_FRAMES + 1);
  localparam int TCW = (ACK_TIMEOUT    < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);

  function automatic logic [9:0] tile_x(input int col);
    return 10'(((col - 1) << 5) + 144);
  endfunction

  function automatic logic [9:0] tile_y(input int row);
    return 10'(((row - 1) << 5) + 66);
  endfunction

  localparam logic [9:0] GX0 = tile_x(18), GY0 = tile_y(3);
  localparam logic [9:0] GX1 = tile_x(3),  GY1 = tile_y(2);
  localparam logic [9:0] GX2 = tile_x(19), GY2 = tile_y(2);
  localparam logic [9:0] GX3 = tile_x(19), GY3 = tile_y(13);

  state_e           state_q, state_d;
  logic [DCW-1:0]   dwell_q, dwell_d, dwell_inc;
  logic [LCW-1:0]   lock_q, lock_d;
  logic [TCW-1:0]   tmo_q, tmo_d;
  logic [7:0]       win_count_q, win_count_d;
  logic             in_goal_q, in_goal_d;
  logic [2:0]       level_q;
  logic             level_chg;
  logic [9:0]       x_pos, y_pos, goal_x, goal_y;
  logic signed [10:0] dx, dy;
  logic             unused_state_bits;

  assign x_pos = playerState[31:22];
  assign y_pos = playerState[21:12];
  assign unused_state_bits = ^playerState[11:0];

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    goal_x = GX0;
    goal_y = GY0;
    unique case (level_num[1:0])
      2'd0: begin goal_x = GX0; goal_y = GY0; end
      2'd1: begin goal_x = GX1; goal_y = GY1; end
      2'd2: begin goal_x = GX2; goal_y = GY2; end
      2'd3: begin goal_x = GX3; goal_y = GY3; end
    endcase
    dx = $signed({1'b0, x_pos}) - $signed({1'b0, goal_x});
    dy = $signed({1'b0, y_pos}) - $signed({1'b0, goal_y});
    in_goal_d = !level_num[2]
             && (dx > -11'sd16) && (dx < 11'sd16)
             && (dy > -11'sd16) && (dy < 11'sd16);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sim_clk) begin
    if (reset) begin
      state_q     <= ARMED;
      dwell_q     <= '0;
      lock_q      <= '0;
      tmo_q       <= '0;
      win_count_q <= '0;
      in_goal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      dwell_q     <= dwell_d;
      lock_q      <= lock_d;
      tmo_q       <= tmo_d;
      win_count_q <= win_count_d;
      in_goal_q   <= in_goal_d;
    end
  end

  // NOTE: level history tracks the input even in reset, so leaving reset never looks like a level change.
  always_ff @(posedge sim_clk) begin
    level_q <= level_num;
  end

  assign level_chg = (level_num != level_q);
  assign dwell_inc = dwell_q + DCW'(1);

  always_comb begin
    state_d     = state_q;
    dwell_d     = dwell_q;
    lock_d      = lock_q;
    tmo_d       = tmo_q;
    win_count_d = win_count_q;
    unique case (state_q)
      ARMED, DWELL: begin
        // A level change outranks a coincident frame tick.
        if (level_chg) begin
          state_d = ARMED;
          dwell_d = '0;
        end else if (frame_tick) begin
          if (!in_goal_q) begin
            state_d = ARMED;
            dwell_d = '0;
          end else begin
            dwell_d = dwell_inc;
            state_d = (dwell_inc == DCW'(DWELL_FRAMES)) ? WIN : DWELL;
          end
        end
      end
      WIN: begin
        dwell_d = '0;
        tmo_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (nextLevel) begin
          win_count_d = (win_count_q == 8'hFF) ? win_count_q : win_count_q + 8'd1;
          lock_d      = LCW'(LOCKOUT_FRAMES);
          state_d     = LOCKOUT;
        end else if (tmo_q == TCW'(ACK_TIMEOUT - 1)) begin
          state_d = WIN;
        end else begin
          tmo_d = tmo_q + TCW'(1);
        end
      end
      LOCKOUT: begin
        if (frame_tick) begin
          if (lock_q <= LCW'(1)) begin
            lock_d  = '0;
            state_d = ARMED;
          end else begin
            lock_d = lock_q - LCW'(1);
          end
        end
      end
      default: state_d = ARMED;
    endcase
  end

  always_comb begin
    playerWin = (state_q == WIN);
    busy      = (state_q == WIN) || (state_q == WAIT_ACK) || (state_q == LOCKOUT);
  end

  assign in_goal   = in_goal_q;
  assign win_count = win_count_q;

endmodule

// File: tb/tb_win_detector.sv
// Bench for win_detector: goal-overlap vector table plus hand-built dwell/ack/lockout sequences.
module tb_win_detector;

  logic        sim_clk = 1'b0;
  logic        reset, frame_tick, nextLevel;
  logic [31:0] playerState;
  logic [2:0]  level_num;
  logic        playerWin, in_goal, busy;
  logic [7:0]  win_count;

  win_detector dut (
    .sim_clk    (sim_clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .playerState(playerState),
    .level_num  (level_num),
    .nextLevel  (nextLevel),
    .playerWin  (playerWin),
    .in_goal    (in_goal),
    .win_count  (win_count),
    .busy       (busy)
  );

  always #5 sim_clk = ~sim_clk;

  typedef struct {
    logic       pw;
    logic       busy;
    logic       ig;
    logic [7:0] wc;
  } exp_t;

  typedef struct {
    logic [2:0] lvl;
    logic [9:0] x;
    logic [9:0] y;
    logic       ig;
  } ig_vec_t;

  exp_t    sbq[$];
  ig_vec_t ig_tab[$];
  int      n_vec = 0;
  int      n_err = 0;
  logic [7:0] exp_wc = 8'd0;
  logic       exp_ig = 1'b0;

  function automatic logic [31:0] pos(input logic [9:0] x, input logic [9:0] y);
    return {x, y, 12'h5A5};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge, then compare.
  task automatic step(input logic rst, input logic ft, input logic nl,
                      input logic pw_e, input logic busy_e, input string tag);
    exp_t e;
    @(negedge sim_clk);
    reset = rst; frame_tick = ft; nextLevel = nl;
    e.pw = pw_e; e.busy = busy_e; e.ig = exp_ig; e.wc = exp_wc;
    sbq.push_back(e);
    @(posedge sim_clk);
    #1;
    e = sbq.pop_front();
    n_vec++;
    check({tag, ".playerWin"}, 32'(playerWin), 32'(e.pw));
    check({tag, ".busy"},      32'(busy),      32'(e.busy));
    check({tag, ".in_goal"},   32'(in_goal),   32'(e.ig));
    check({tag, ".win_count"}, 32'(win_count), 32'(e.wc));
  endtask

  task automatic idle(input logic pw_e, input logic busy_e, input string tag);
    step(1'b0, 1'b0, 1'b0, pw_e, busy_e, tag);
  endtask

  task automatic tick(input logic pw_e, input logic busy_e, input string tag);
    step(1'b0, 1'b1, 1'b0, pw_e, busy_e, tag);
  endtask

  task automatic dwell_to_win(input int gap, input string tag);
    for (int k = 1; k <= 4; k++) begin
      tick(k == 4, k == 4, tag);
      if (k < 4) repeat (gap) idle(1'b0, 1'b0, tag);
    end
  endtask

  task automatic acknowledge(input string tag);
    exp_wc = (exp_wc == 8'hFF) ? exp_wc : exp_wc + 8'd1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, tag);
  endtask

  task automatic lockout(input int gap, input string tag);
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, k < 8, tag);
      if (k < 8) repeat (gap) idle(1'b0, 1'b1, tag);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; nextLevel = 1'b0;
    level_num = 3'd0; playerState = pos(10'd0, 10'd0);

    exp_wc = 8'd0; exp_ig = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "reset0");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "reset1");

    ig_tab.push_back('{3'd0, 10'd688,  10'd130, 1'b1});
    ig_tab.push_back('{3'd0, 10'd703,  10'd130, 1'b1});
    ig_tab.push_back('{3'd0, 10'd704,  10'd130, 1'b0});
    ig_tab.push_back('{3'd0, 10'd673,  10'd145, 1'b1});
    ig_tab.push_back('{3'd0, 10'd672,  10'd130, 1'b0});
    ig_tab.push_back('{3'd0, 10'd688,  10'd146, 1'b0});
    ig_tab.push_back('{3'd0, 10'd0,    10'd0,   1'b0});
    ig_tab.push_back('{3'd0, 10'd1023, 10'd130, 1'b0});
    ig_tab.push_back('{3'd1, 10'd208,  10'd98,  1'b1});
    ig_tab.push_back('{3'd1, 10'd688,  10'd130, 1'b0});
    ig_tab.push_back('{3'd2, 10'd720,  10'd98,  1'b1});
    ig_tab.push_back('{3'd2, 10'd720,  10'd114, 1'b0});
    ig_tab.push_back('{3'd3, 10'd720,  10'd450, 1'b1});
    ig_tab.push_back('{3'd3, 10'd735,  10'd465, 1'b1});
    ig_tab.push_back('{3'd3, 10'd720,  10'd434, 1'b0});
    ig_tab.push_back('{3'd5, 10'd688,  10'd130, 1'b0});
    ig_tab.push_back('{3'd4, 10'd720,  10'd450, 1'b0});
    ig_tab.push_back('{3'd7, 10'd208,  10'd98,  1'b0});
    ig_tab.push_back('{3'd0, 10'd688,  10'd130, 1'b1});

    foreach (ig_tab[i]) begin
      level_num   = ig_tab[i].lvl;
      playerState = pos(ig_tab[i].x, ig_tab[i].y);
      exp_ig      = ig_tab[i].ig;
      idle(1'b0, 1'b0, $sformatf("ig_tab[%0d]", i));
    end

    // Stray acknowledge while armed must not count.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ack_in_armed");

    // Basic win, then unacknowledged retries every five cycles.
    dwell_to_win(1, "basic_win");
    for (int i = 1; i <= 10; i++) idle(i % 5 == 0, 1'b1, $sformatf("retry[%0d]", i));
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "ack_during_win");
    acknowledge("ack1");

    // Lockout ignores a player still in goal; a fresh dwell follows.
    lockout(1, "lockout1");
    dwell_to_win(1, "post_lockout_win");
    idle(1'b0, 1'b1, "wait_ack2");
    acknowledge("ack2");
    lockout(0, "lockout2");

    // Interrupted dwell restarts from zero.
    for (int k = 0; k < 3; k++) begin
      tick(1'b0, 1'b0, "dwell3");
      idle(1'b0, 1'b0, "dwell3_gap");
    end
    playerState = pos(10'd0, 10'd0); exp_ig = 1'b0;
    idle(1'b0, 1'b0, "leave_goal");
    tick(1'b0, 1'b0, "tick_out");
    playerState = pos(10'd688, 10'd130); exp_ig = 1'b1;
    idle(1'b0, 1'b0, "reenter_goal");
    dwell_to_win(1, "second_run");
    idle(1'b0, 1'b1, "wait_ack3");
    acknowledge("ack3");
    lockout(0, "lockout3");

    // Level change coinciding with a tick clears the dwell.
    tick(1'b0, 1'b0, "pre_chg1");
    tick(1'b0, 1'b0, "pre_chg2");
    level_num = 3'd1; playerState = pos(10'd208, 10'd98); exp_ig = 1'b1;
    tick(1'b0, 1'b0, "chg_with_tick");
    idle(1'b0, 1'b0, "after_chg");
    dwell_to_win(1, "level1_win");
    idle(1'b0, 1'b1, "wait_ack4");
    acknowledge("ack4");
    level_num = 3'd0; playerState = pos(10'd688, 10'd130); exp_ig = 1'b1;
    lockout(1, "chg_in_lockout");

    // Reset in WAIT_ACK wins over a coincident acknowledge.
    dwell_to_win(0, "pre_reset_win");
    idle(1'b0, 1'b1, "wait_ack5");
    exp_wc = 8'd0; exp_ig = 1'b0;
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "reset_in_wait_ack");
    exp_ig = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ack_after_reset");
    idle(1'b0, 1'b0, "post_reset_idle");

    // Out-of-range level never reports the goal.
    level_num = 3'd5; exp_ig = 1'b0;
    idle(1'b0, 1'b0, "level5_enter");
    for (int k = 0; k < 6; k++) tick(1'b0, 1'b0, "level5_tick");
    playerState = pos(10'd720, 10'd450);
    for (int k = 0; k < 3; k++) tick(1'b0, 1'b0, "level5_pos2");

    // Saturating win counter.
    level_num = 3'd0; playerState = pos(10'd688, 10'd130); exp_ig = 1'b1;
    idle(1'b0, 1'b0, "level0_back");
    for (int w = 0; w < 256; w++) begin
      dwell_to_win(0, "sat_win");
      idle(1'b0, 1'b1, "sat_wait");
      acknowledge("sat_ack");
      lockout(0, "sat_lockout");
    end
    check("final_win_count", 32'(win_count), 32'd255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/win_detector.md
WIN_DETECTOR -- requirements
Module: win_detector

Interface
REQ-001 Parameter DWELL_FRAMES, default 4: number of consecutive in-goal frame_tick samples needed to declare a win.
REQ-002 Parameter LOCKOUT_FRAMES, default 8: number of frame_ticks ignored after a level change is acknowledged.
REQ-003 Parameter ACK_TIMEOUT, default 4: number of sim_clk cycles to wait for nextLevel before playerWin is re-pulsed.
REQ-004 sim_clk  input  1  system clock; all logic rising-edge.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 frame_tick  input  1  one-cycle pulse, once per video frame.
REQ-007 playerState  input  32  packed {xPos[9:0], yPos[9:0], xSpeed[4:0], ySpeed[4:0], xDir, yDir}; only xPos and yPos are used.
REQ-008 level_num  input  3  current level index, 0..3.
REQ-009 nextLevel  input  1  acknowledge from the level controller.
REQ-010 playerWin  output  1  one-cycle win request pulse.
REQ-011 in_goal  output  1  registered, combinational-equivalent goal-overlap status.
REQ-012 win_count  output  8  total acknowledged wins, saturating.
REQ-013 busy  output  1  high in the WIN, WAIT_ACK and LOCKOUT states.

Function
REQ-014 Goal tile per level (row, col, 1-indexed): level 0 = (3,18), level 1 = (2,3), level 2 = (2,19), level 3 = (13,19).
REQ-015 Goal pixel coordinates: gx = ((col-1)<<5)+144 and gy = ((row-1)<<5)+66, held in 10-bit constants.
REQ-016 in_goal is computed with 11-bit signed differences: |xPos-gx|<16 AND |yPos-gy|<16.
REQ-017 in_goal is registered every sim_clk cycle.
REQ-018 level_num values 4..7 force in_goal to 0.
REQ-019 FSM states: ARMED, DWELL, WIN, WAIT_ACK, LOCKOUT.
REQ-020 ARMED: on frame_tick with in_goal=1, the dwell counter is set to 1 and the FSM goes to DWELL.
REQ-021 DWELL: on frame_tick with in_goal=1, the dwell counter increments; when it reaches DWELL_FRAMES the FSM goes to WIN.
REQ-022 DWELL: on frame_tick with in_goal=0, the dwell counter clears and the FSM returns to ARMED.
REQ-023 WIN: playerWin is asserted for exactly one cycle, the timeout counter clears, and the FSM goes to WAIT_ACK.
REQ-024 WAIT_ACK: nextLevel=1 increments win_count (saturating at 255), loads the lockout counter with LOCKOUT_FRAMES, and the FSM goes to LOCKOUT.
REQ-025 WAIT_ACK: if ACK_TIMEOUT cycles elapse without nextLevel, the FSM returns to WIN and playerWin is re-pulsed; retries are unlimited.
REQ-026 LOCKOUT: each frame_tick decrements the lockout counter; at 0 the FSM goes to ARMED and in_goal is not sampled during LOCKOUT.
REQ-027 A level_num change observed in ARMED or DWELL clears the dwell counter and forces the FSM to ARMED.
REQ-028 A level_num change observed in WAIT_ACK or LOCKOUT is ignored.
REQ-029 nextLevel received outside WAIT_ACK is ignored and does not change win_count.
REQ-030 When frame_tick and a level_num change occur in the same cycle, the level change takes priority: no dwell increment occurs.
REQ-031 playerWin is never high on two consecutive cycles.
REQ-032 Latency: playerWin rises 1 cycle after the frame_tick that completes the dwell.

Reset
REQ-033 On reset=1, the FSM goes to ARMED and all counters clear.
REQ-034 On reset=1, playerWin=0, in_goal=0, win_count=0 and busy=0 on the next edge.
REQ-035 reset has priority over all other inputs in every state, including mid-WAIT_ACK, where no win is counted.

Verification
REQ-036 level 0, player at (688,130) for 4 frame_ticks -> playerWin pulses once, 1 cycle after the 4th tick; busy=1.
REQ-037 level 0, in goal for 3 ticks, out on the 4th, then in for 4 ticks -> exactly one playerWin, after the final run of 4 ticks.
REQ-038 win issued, nextLevel withheld for 10 cycles -> playerWin re-pulses every 5 cycles; nextLevel then given -> win_count=1, state LOCKOUT.
REQ-039 after ack, player still in goal -> no playerWin during the 8 lockout ticks; a new win follows 4 ticks after lockout ends.
REQ-040 reset asserted in WAIT_ACK -> next cycle playerWin=0, win_count=0, busy=0; a later nextLevel has no effect.
REQ-041 level_num=5 with the player at any position -> in_goal=0 and no playerWin; 256 wins -> win_count holds at 255.
